// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundle between the ID-stage decoder and the issue scoreboard.
//
//   Handshake: id_valid qualifies every id_* field in the same cycle. flush
//   squashes that instruction. issue=1 means the instruction moves into ID/EX
//   on the next rising edge. stall=1 means the decoder holds PC and IF/ID and
//   presents the same instruction again. issue and stall are never both 1.
//
//   master : decoder side (drives id_*, flush; observes the decisions)
//   slave  : scoreboard side
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int LAT_W = 3
);
  localparam int REG_W = $clog2(NREG);

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_regwrite;
  logic [REG_W-1:0] id_rd;
  logic [LAT_W-1:0] id_lat;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [NREG-1:0]  busy_mask;
  logic [31:0]      stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_regwrite, id_rd, id_lat, flush,
    input  stall, issue, busy_mask, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_regwrite, id_rd, id_lat, flush,
    output stall, issue, busy_mask, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Decides whether the ID-stage instruction may issue. A per-register
//   countdown tracks results that are not yet forwardable (loads, MUL/DIV).
//   The block stalls on RAW and WAW conflicts against those results. It also
//   stalls when a new long-latency writer would exceed MAX_INF in-flight
//   entries.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous reset, active-high; clears all countdowns
//     sb   : hazard_scoreboard_if.slave
//            (id_* decode fields and flush in; stall, issue, busy_mask and
//            stall_cycles out)
//
//   Optional feature
//     HAZARD_SCOREBOARD_STATS_EN : when defined, stall_cycles counts clocks
//     with stall=1 and wraps at 2^32. It is cleared only by rst. When not
//     defined, stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int LAT_W   = 3,
  parameter int MAX_INF = 4
) (
  input logic             clk,
  input logic             rst,
  hazard_scoreboard_if.slave sb
);
  localparam int CNT_W = $clog2(NREG + 1);

  logic [LAT_W-1:0] cnt     [NREG];
  logic [LAT_W-1:0] cntNext [NREG];

  logic [CNT_W-1:0] inflight;
  logic [NREG-1:0]  busyMask;
  logic             raw;
  logic             waw;
  logic             full;
  logic             live;
  logic             stallInt;
  logic             issueInt;
  logic             alloc;
  logic             rdNonZero;

  // Register 0 is never written, so its countdown stays zero.
  // Occupancy is the popcount of nonzero countdowns.
  always_comb begin
    inflight = '0;
    busyMask = '0;
    for (int r = 1; r < NREG; r++) begin
      if (cnt[r] != '0) begin
        inflight    = inflight + CNT_W'(1);
        busyMask[r] = 1'b1;
      end
    end
  end

  always_comb begin
    rdNonZero = (sb.id_rd != '0);
    raw  = (sb.id_rs1_used && (sb.id_rs1 != '0) && (cnt[sb.id_rs1] != '0)) ||
           (sb.id_rs2_used && (sb.id_rs2 != '0) && (cnt[sb.id_rs2] != '0));
    // An older writer to rd that lands after this one would clobber the
    // newer value, so wait until it lands no later than the new result.
    waw  = sb.id_regwrite && rdNonZero && (cnt[sb.id_rd] > sb.id_lat);
    // Only a writer that would claim a fresh entry can overflow the table.
    // Re-targeting an already-busy register reuses its entry.
    full = sb.id_regwrite && rdNonZero && (sb.id_lat != '0) &&
           (cnt[sb.id_rd] == '0) && (inflight == CNT_W'(MAX_INF));
    // A flushed instruction is dead, so it must never hold up the front end.
    live     = sb.id_valid && !sb.flush;
    stallInt = live && (raw || waw || full);
    issueInt = live && !stallInt;
    alloc    = issueInt && sb.id_regwrite && rdNonZero && (sb.id_lat != '0);
  end

  // Countdowns drain one per clock and saturate at zero. A new allocation
  // replaces the same-cycle decrement of its entry.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cntNext[r] = '0;
      if (r != 0) begin
        if (alloc && (int'(sb.id_rd) == r)) begin
          cntNext[r] = sb.id_lat;
        end else if (cnt[r] != '0) begin
          cntNext[r] = cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cntNext[r];
    end
  end

  assign sb.stall     = stallInt;
  assign sb.issue     = issueInt;
  assign sb.busy_mask = busyMask;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stallCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= 32'd0;
    end else if (stallInt) begin
      stallCount <= stallCount + 32'd1;
    end
  end

  assign sb.stall_cycles = stallCount;
`else
  assign sb.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int NREG    = 32;
  localparam int LAT_W   = 3;
  localparam int MAX_INF = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .LAT_W(LAT_W)) bus ();

  hazard_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .MAX_INF(MAX_INF)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  // ---------------- reference model ----------------
  // ready_at[r]: the first cycle in which a reader of r may issue.
  // The remaining wait in cycle c is max(0, ready_at[r] - c).
  int ready_at [NREG];
  int cycle      = 0;
  int stat_count = 0;
  int errors     = 0;
  int checks     = 0;
  logic [1:0] exp_q [$];

  function automatic int remaining(input int r);
    if (r == 0) return 0;
    return (ready_at[r] > cycle) ? ready_at[r] - cycle : 0;
  endfunction

  function automatic int in_flight();
    int n = 0;
    for (int r = 1; r < NREG; r++) if (remaining(r) > 0) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw,
                       input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_regwrite = rw;
    bus.id_rd       = rd;
    bus.id_lat      = lat;
    bus.flush       = fl;
  endtask

  // One clock: drive, compare against the model, then advance the model
  // across the rising edge.
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic rw,
                      input logic [4:0] rd, input logic [2:0] lat, input logic fl,
                      output logic got_stall, output logic got_issue);
    logic raw, waw, full, e_stall, e_issue;
    logic [1:0] e_pair;
    logic [NREG-1:0] e_mask;
    @(negedge clk);
    drive(v, rs1, rs2, u1, u2, rw, rd, lat, fl);
    #1;
    raw  = (u1 && rs1 != 0 && remaining(int'(rs1)) > 0) ||
           (u2 && rs2 != 0 && remaining(int'(rs2)) > 0);
    waw  = rw && rd != 0 && remaining(int'(rd)) > int'(lat);
    full = rw && rd != 0 && lat != 0 && remaining(int'(rd)) == 0 && in_flight() == MAX_INF;
    e_stall = v && !fl && (raw || waw || full);
    e_issue = v && !fl && !e_stall;
    e_mask = '0;
    for (int r = 1; r < NREG; r++) e_mask[r] = (remaining(r) > 0);
    exp_q.push_back({e_stall, e_issue});
    e_pair = exp_q.pop_front();
    check("stall", 32'(bus.stall), 32'(e_pair[1]));
    check("issue", 32'(bus.issue), 32'(e_pair[0]));
    check("busy_mask", bus.busy_mask, e_mask);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check("stall_cycles", bus.stall_cycles, 32'(stat_count));
`else
    check("stall_cycles", bus.stall_cycles, 32'd0);
`endif
    got_stall = bus.stall;
    got_issue = bus.issue;
    if (e_issue && rw && rd != 0 && lat != 0) ready_at[rd] = cycle + 1 + int'(lat);
    if (e_stall) stat_count++;
    cycle++;
  endtask

  task automatic idle();
    logic s, i;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, s, i);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    stat_count = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic s, i;
    int n_stall, n_busy, guard;
    logic [4:0] r1, r2, rd;
    logic [2:0] lat;
    model_reset();
    // Reset state: a live instruction issues straight through.
    drive(1, 5, 6, 1, 1, 1, 7, 3, 0);
    #2;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_issue", 32'(bus.issue), 32'd1);
    check("rst_busy", bus.busy_mask, 32'd0);
    check("rst_stats", bus.stall_cycles, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle = 10;

    // 1: load x5, then add x6,x5,x1 stalls one cycle.
    step(1, 0, 0, 0, 0, 1, 5, 1, 0, s, i);
    step(1, 5, 1, 1, 1, 1, 6, 0, 0, s, i);
    check("s1_stall", 32'(s), 32'd1);
    step(1, 5, 1, 1, 1, 1, 6, 0, 0, s, i);
    check("s1_issue", 32'(i), 32'd1);

    // 2: DIV x7 lat 4 then a reader every cycle: exactly four stalls.
    idle();
    step(1, 0, 0, 0, 0, 1, 7, 4, 0, s, i);
    n_stall = 0; n_busy = 0; guard = 0;
    do begin
      step(1, 7, 0, 1, 0, 0, 0, 0, 0, s, i);
      if (s) n_stall++;
      if (bus.busy_mask[7]) n_busy++;
      guard++;
    end while (s && guard < 10);
    check("s2_stalls", 32'(n_stall), 32'd4);
    check("s2_busy", 32'(n_busy), 32'd4);

    // 3: WAW against a DIV, first with an ALU op, then with a load.
    step(1, 0, 0, 0, 0, 1, 7, 4, 0, s, i);
    n_stall = 0; guard = 0;
    do begin
      step(1, 0, 0, 0, 0, 1, 7, 0, 0, s, i);
      if (s) n_stall++;
      guard++;
    end while (s && guard < 10);
    check("s3_waw_alu", 32'(n_stall), 32'd4);
    idle();
    step(1, 0, 0, 0, 0, 1, 7, 4, 0, s, i);
    n_stall = 0; guard = 0;
    do begin
      step(1, 0, 0, 0, 0, 1, 7, 1, 0, s, i);
      if (s) n_stall++;
      guard++;
    end while (s && guard < 10);
    check("s3_waw_ld", 32'(n_stall), 32'd3);

    // 4: occupancy cap.
    for (int k = 0; k < 6; k++) idle();
    for (int k = 1; k <= 4; k++) step(1, 0, 0, 0, 0, 1, 5'(k), 4, 0, s, i);
    step(1, 0, 0, 0, 0, 1, 9, 4, 0, s, i);
    check("s4_full", 32'(s), 32'd1);
    step(1, 0, 0, 0, 0, 1, 9, 4, 0, s, i);
    check("s4_full_rel", 32'(i), 32'd1);
    for (int k = 0; k < 6; k++) idle();
    for (int k = 1; k <= 4; k++) step(1, 0, 0, 0, 0, 1, 5'(k), 4, 0, s, i);
    step(1, 0, 0, 0, 0, 1, 1, 4, 0, s, i);
    check("s4_reuse", 32'(i), 32'd1);

    // 5: flush beats stall; x0 never conflicts.
    step(1, 0, 0, 0, 0, 1, 8, 5, 0, s, i);
    step(1, 8, 0, 1, 0, 0, 0, 0, 1, s, i);
    check("s5_flush_stall", 32'(s), 32'd0);
    check("s5_flush_issue", 32'(i), 32'd0);
    step(1, 0, 0, 1, 1, 1, 0, 7, 0, s, i);
    check("s5_x0", 32'(i), 32'd1);

    // 6: asynchronous reset while cnt[3]=2.
    for (int k = 0; k < 8; k++) idle();
    step(1, 0, 0, 0, 0, 1, 3, 3, 0, s, i);
    idle();
    @(negedge clk);
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check("s6_pre_busy", 32'(bus.busy_mask[3]), 32'd1);
    check("s6_pre_stall", 32'(bus.stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("s6_busy", bus.busy_mask, 32'd0);
    check("s6_stall", 32'(bus.stall), 32'd0);
    check("s6_issue", 32'(bus.issue), 32'd1);
    check("s6_stats", bus.stall_cycles, 32'd0);
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle += 2;

    // Randomized traffic on a small register window to provoke conflicts.
    for (int k = 0; k < 400; k++) begin
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      lat = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      step($urandom_range(0, 9) != 0, r1, r2, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, lat,
           $urandom_range(0, 9) == 0, s, i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
